dcache_responder: RTL and testbench
===================================

DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width (from rapid_pkg).
REQ-002 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of 2).
REQ-003 SHALL have parameter WORDS_PER_LINE, default 4, XLEN-bit words per line (power of 2).
REQ-004 SHALL have port i_clk  in  1  clock; all logic on its rising edge.
REQ-005 SHALL have port i_reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_req  in  1  request valid from memory stage.
REQ-007 SHALL have port o_ready  out  1  request can be accepted this cycle.
REQ-008 SHALL have port i_address  in  XLEN  byte address.
REQ-009 SHALL have port i_write_data  in  XLEN  store data, right-aligned.
REQ-010 SHALL have port i_read_or_write  in  cache_rw  CACHE_READ or CACHE_WRITE.
REQ-011 SHALL have port i_operation  in  cache_operation  CACHE_BYTE, CACHE_HALF or CACHE_WORD.
REQ-012 SHALL have port o_data  out  XLEN  load data, right-aligned, zero-extended.
REQ-013 SHALL have port o_done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port o_misaligned  out  1  qualifies o_done; access rejected.
REQ-015 SHALL have ports o_mem_req out 1, o_mem_we out 1, o_mem_addr out XLEN (word-aligned), o_mem_wdata out XLEN, o_mem_wstrb out XLEN/8: backing-memory request.
REQ-016 SHALL have ports i_mem_ack in 1, i_mem_rdata in XLEN: backing-memory response; rdata valid in the ack cycle.

Function
REQ-017 SHALL decode address as offset[1:0], word[log2(WORDS_PER_LINE)+1:2], index[next log2(LINES) bits], tag = remaining upper bits.
REQ-018 SHALL implement FSM IDLE, LOOKUP, REFILL, WRITE_MEM, RESP; o_ready high only in IDLE.
REQ-019 SHALL accept a request when i_req && o_ready, registering address, data, rw and operation; IDLE -> LOOKUP.
REQ-020 SHALL, in LOOKUP, flag misaligned if HALF with offset[0]=1 or WORD with offset!=0 -> RESP with o_misaligned=1, no cache or memory change.
REQ-021 SHALL, on read hit in LOOKUP, go to RESP; o_done asserted the cycle after LOOKUP (2 cycles after accept edge).
REQ-022 SHALL, on read miss, enter REFILL: fetch words 0..WORDS_PER_LINE-1 of the line in order, o_mem_req=1, o_mem_we=0, beat counter advancing on each i_mem_ack; after last beat write tag, set valid, go to RESP.
REQ-023 SHALL, on write (hit or miss), write-through no-allocate: on hit merge bytes into line in LOOKUP; always enter WRITE_MEM with o_mem_we=1 and byte strobes; hold until i_mem_ack, then RESP.
REQ-024 SHALL generate strobes: BYTE 1<<offset; HALF 3<<offset; WORD all ones; o_mem_wdata = store data shifted by 8*offset.
REQ-025 SHALL hold o_mem_req/addr/we/wdata/wstrb stable until i_mem_ack; drop o_mem_req the cycle after the final ack.
REQ-026 SHALL, in RESP, pulse o_done for exactly one cycle, drive o_data (reads only, else 0), then return to IDLE.
REQ-027 SHALL ignore i_req while o_ready=0; back-to-back requests spaced at least one IDLE cycle.

Reset
REQ-028 SHALL on i_reset: state IDLE, all valid bits 0, beat counter 0, o_done=0, o_misaligned=0, o_mem_req=0, o_mem_we=0, o_data=0; o_ready=1 after reset.
REQ-029 SHALL, on reset mid-REFILL or mid-WRITE_MEM, abort: o_mem_req low next cycle, partially refilled line left invalid, no o_done.

Structure
REQ-030 SHALL take XLEN, cache_rw and cache_operation from rapid_pkg; add DCACHE_LINES and DCACHE_WORDS_PER_LINE defaults there.
REQ-031 SHALL place tag/valid/data storage in one sub-module dcache_line_ram (1 read port, 1 byte-enabled write port, valid clear on reset).

Verification
REQ-032 Read WORD 0x0000_0100 after reset -> 4 refill beats at 0x100,0x104,0x108,0x10C; o_data=rdata of beat 0; repeat read -> hit, o_done 2 cycles after accept, no o_mem_req.
REQ-033 Read BYTE 0x0000_0103 after line 0x100 filled with word 0xAABBCCDD -> o_data=0x0000_00AA.
REQ-034 Write HALF 0x1234 to 0x0000_0102 (hit) -> o_mem_wstrb=4'b1100, o_mem_wdata=0x1234_0000; subsequent WORD read of 0x100 -> 0x1234CCDD, no refill.
REQ-035 Read HALF 0x0000_0101 -> o_done with o_misaligned=1, o_mem_req never asserted.
REQ-036 Conflict: read 0x100 then 0x200 (same index) -> second refills; read 0x100 again -> refill again.
REQ-037 Assert i_reset during 3rd refill beat -> o_mem_req low next cycle, no o_done; read same address -> full 4-beat refill.

Source files
------------

// File: rtl/rapid_pkg.sv
// rapid_pkg: shared datapath width, cache request encodings and data-cache defaults
//   XLEN                  data/address width
//   DCACHE_LINES          default number of direct-mapped lines
//   DCACHE_WORDS_PER_LINE default XLEN-bit words per line
//   cache_rw, cache_operation  request kind and access size
//   dcache_state          responder FSM states
package rapid_pkg;
    localparam int XLEN = 32;
    localparam int DCACHE_LINES = 16;
    localparam int DCACHE_WORDS_PER_LINE = 4;
    typedef enum logic {CACHE_READ, CACHE_WRITE} cache_rw;
    typedef enum logic [1:0] {CACHE_BYTE, CACHE_HALF, CACHE_WORD} cache_operation;
    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE_MEM, RESP} dcache_state;
endpackage

// File: rtl/dcache_line_ram.sv
// dcache_line_ram: direct-mapped tag/valid/data store with one async read port and one byte-enabled write port
//   i_index          line selected for both ports
//   i_rd_word        word read onto o_rd_data; o_rd_valid/o_rd_tag describe the selected line
//   i_we/i_wr_word/i_wr_data/i_wr_strb  byte-enabled word write
//   i_tag_we/i_tag   install tag and set valid; i_inval clears valid; i_reset clears every valid bit
module dcache_line_ram #(
    parameter int XLEN = 32,
    parameter int LINES = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W = 24
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [$clog2(LINES)-1:0]          i_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] i_rd_word,
    output logic                              o_rd_valid,
    output logic [TAG_W-1:0]                  o_rd_tag,
    output logic [XLEN-1:0]                   o_rd_data,
    input  logic                              i_we,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] i_wr_word,
    input  logic [XLEN-1:0]                   i_wr_data,
    input  logic [XLEN/8-1:0]                 i_wr_strb,
    input  logic                              i_tag_we,
    input  logic [TAG_W-1:0]                  i_tag,
    input  logic                              i_inval
);
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [XLEN-1:0] data [LINES*WORDS_PER_LINE];

    assign o_rd_valid = valid[i_index];
    assign o_rd_tag = tags[i_index];
    assign o_rd_data = data[{i_index, i_rd_word}];

    always_ff @(posedge i_clk) begin
        if (i_reset)
            valid <= '0;
        else if (i_inval)
            valid[i_index] <= 1'b0;
        else if (i_tag_we)
            valid[i_index] <= 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_tag_we)
            tags[i_index] <= i_tag;
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < XLEN/8; b++)
            if (i_we && i_wr_strb[b])
                data[{i_index, i_wr_word}][8*b +: 8] <= i_wr_data[8*b +: 8];
    end
endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-through no-allocate data cache between memory stage and backing memory
//   i_req/o_ready/i_address/i_write_data/i_read_or_write/i_operation  request from memory stage
//   o_data/o_done/o_misaligned   one-cycle response; o_data right-aligned, zero-extended
//   o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata/o_mem_wstrb  word-aligned backing-memory request
//   i_mem_ack/i_mem_rdata        backing-memory response, rdata valid in the ack cycle
module dcache_responder
    import rapid_pkg::*;
#(
    parameter int XLEN = rapid_pkg::XLEN,
    parameter int LINES = DCACHE_LINES,
    parameter int WORDS_PER_LINE = DCACHE_WORDS_PER_LINE
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_req,
    output logic           o_ready,
    input  logic [XLEN-1:0] i_address,
    input  logic [XLEN-1:0] i_write_data,
    input  cache_rw        i_read_or_write,
    input  cache_operation i_operation,
    output logic [XLEN-1:0] o_data,
    output logic           o_done,
    output logic           o_misaligned,
    output logic           o_mem_req,
    output logic           o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_wstrb,
    input  logic           i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata
);
    localparam int SW = XLEN/8;
    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(LINES);
    localparam int TW = XLEN - 2 - WB - IB;

    dcache_state state;
    logic [XLEN-1:0] addr_q, wdata_q, load_word;
    cache_rw rw_q;
    cache_operation op_q;
    logic [WB-1:0] beat, beat_next, word;
    logic [1:0] off;
    logic [IB-1:0] idx;
    logic [TW-1:0] tag, rd_tag;
    logic rd_valid, misaligned, hit, last_beat;
    logic [XLEN-1:0] rd_data, wdata_sh, fill_word, ram_wdata;
    logic [SW-1:0] strb, ram_wstrb;
    logic ram_we, ram_tag_we, ram_inval;
    logic [WB-1:0] ram_word;

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w, input logic [1:0] o, input cache_operation op);
        logic [XLEN-1:0] s;
        s = w >> {o, 3'b000};
        return op == CACHE_BYTE ? {{(XLEN-8){1'b0}}, s[7:0]} :
               op == CACHE_HALF ? {{(XLEN-16){1'b0}}, s[15:0]} : s;
    endfunction

    assign off = addr_q[1:0];
    assign word = addr_q[WB+1:2];
    assign idx = addr_q[WB+IB+1:WB+2];
    assign tag = addr_q[XLEN-1:WB+IB+2];
    assign misaligned = (op_q == CACHE_HALF && off[0]) || (op_q == CACHE_WORD && off != 2'b00);
    assign hit = rd_valid && rd_tag == tag;
    assign strb = op_q == CACHE_BYTE ? SW'(1) << off : op_q == CACHE_HALF ? SW'(3) << off : '1;
    assign wdata_sh = wdata_q << {off, 3'b000};
    assign beat_next = beat + 1'b1;
    assign last_beat = &beat;
    // the requested word may arrive on the final beat, before load_word could capture it
    assign fill_word = beat == word ? i_mem_rdata : load_word;
    assign o_ready = state == IDLE;

    // write hits merge into the line; refill beats write whole words; a read miss
    // invalidates the line first so an aborted refill never leaves stale data valid
    assign ram_we = (state == LOOKUP && rw_q == CACHE_WRITE && !misaligned && hit) || (state == REFILL && i_mem_ack);
    assign ram_tag_we = state == REFILL && i_mem_ack && last_beat;
    assign ram_inval = state == LOOKUP && rw_q == CACHE_READ && !misaligned && !hit;
    assign ram_word = state == REFILL ? beat : word;
    assign ram_wdata = state == REFILL ? i_mem_rdata : wdata_sh;
    assign ram_wstrb = state == REFILL ? '1 : strb;

    dcache_line_ram #(
        .XLEN(XLEN), .LINES(LINES), .WORDS_PER_LINE(WORDS_PER_LINE), .TAG_W(TW)
    ) u_ram (
        .i_clk(i_clk), .i_reset(i_reset), .i_index(idx), .i_rd_word(word),
        .o_rd_valid(rd_valid), .o_rd_tag(rd_tag), .o_rd_data(rd_data),
        .i_we(ram_we), .i_wr_word(ram_word), .i_wr_data(ram_wdata), .i_wr_strb(ram_wstrb),
        .i_tag_we(ram_tag_we), .i_tag(tag), .i_inval(ram_inval)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            beat <= '0;
            o_done <= 1'b0;
            o_misaligned <= 1'b0;
            o_data <= '0;
            o_mem_req <= 1'b0;
            o_mem_we <= 1'b0;
            o_mem_addr <= '0;
            o_mem_wdata <= '0;
            o_mem_wstrb <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            load_word <= '0;
            rw_q <= CACHE_READ;
            op_q <= CACHE_BYTE;
        end else begin
            case (state)
                IDLE: if (i_req) begin
                    addr_q <= i_address;
                    wdata_q <= i_write_data;
                    rw_q <= i_read_or_write;
                    op_q <= i_operation;
                    state <= LOOKUP;
                end
                LOOKUP: if (misaligned) begin
                    o_done <= 1'b1;
                    o_misaligned <= 1'b1;
                    o_data <= '0;
                    state <= RESP;
                end else if (rw_q == CACHE_WRITE) begin
                    o_mem_req <= 1'b1;
                    o_mem_we <= 1'b1;
                    o_mem_addr <= {addr_q[XLEN-1:2], 2'b00};
                    o_mem_wdata <= wdata_sh;
                    o_mem_wstrb <= strb;
                    state <= WRITE_MEM;
                end else if (hit) begin
                    o_done <= 1'b1;
                    o_data <= extract(rd_data, off, op_q);
                    state <= RESP;
                end else begin
                    o_mem_req <= 1'b1;
                    o_mem_we <= 1'b0;
                    o_mem_addr <= {addr_q[XLEN-1:WB+2], {WB{1'b0}}, 2'b00};
                    o_mem_wstrb <= '0;
                    beat <= '0;
                    state <= REFILL;
                end
                REFILL: if (i_mem_ack) begin
                    if (beat == word)
                        load_word <= i_mem_rdata;
                    if (last_beat) begin
                        o_mem_req <= 1'b0;
                        o_done <= 1'b1;
                        o_data <= extract(fill_word, off, op_q);
                        beat <= '0;
                        state <= RESP;
                    end else begin
                        beat <= beat_next;
                        o_mem_addr <= {addr_q[XLEN-1:WB+2], beat_next, 2'b00};
                    end
                end
                WRITE_MEM: if (i_mem_ack) begin
                    o_mem_req <= 1'b0;
                    o_mem_we <= 1'b0;
                    o_done <= 1'b1;
                    o_data <= '0;
                    state <= RESP;
                end
                RESP: begin
                    o_done <= 1'b0;
                    o_misaligned <= 1'b0;
                    o_data <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: directed table plus randomized checks of dcache_responder against a cache/memory model
module tb_dcache_responder;
    import rapid_pkg::*;

    logic i_clk = 1'b0, i_reset, i_req, o_ready, o_done, o_misaligned;
    logic o_mem_req, o_mem_we, i_mem_ack;
    logic [31:0] i_address, i_write_data, o_data, o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic [3:0] o_mem_wstrb;
    cache_rw i_read_or_write;
    cache_operation i_operation;

    always #5 i_clk = ~i_clk;

    dcache_responder dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .o_ready(o_ready),
        .i_address(i_address), .i_write_data(i_write_data), .i_read_or_write(i_read_or_write),
        .i_operation(i_operation), .o_data(o_data), .o_done(o_done), .o_misaligned(o_misaligned),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_wstrb(o_mem_wstrb), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    int n_cmp = 0, n_fail = 0;
    logic [31:0] mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    bit mvalid [16];
    int unsigned mtag [16];
    typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] wstrb;} beat_t;
    beat_t beats_q[$];
    bit slow = 0;
    int wait_cnt = 0;

    typedef struct {
        cache_rw rw; cache_operation op; logic [31:0] addr, wd, e_data;
        bit e_mis; int e_beats; logic [3:0] e_strb; logic [31:0] e_wdata;
    } vec_t;
    vec_t vt[$];

    function automatic logic [31:0] init_word(input int unsigned k);
        return (k * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction
    function automatic logic [31:0] mem_rd(input int unsigned k);
        return mem.exists(k) ? mem[k] : init_word(k);
    endfunction
    function automatic logic [31:0] ref_rd(input int unsigned k);
        return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // reference model: what a direct-mapped write-through no-allocate cache must do
    function automatic bit m_mis(input cache_operation op, input logic [31:0] a);
        return (op == CACHE_HALF && a[0]) || (op == CACHE_WORD && a[1:0] != 2'b00);
    endfunction
    function automatic int m_beats(input cache_rw rw, input cache_operation op, input logic [31:0] a);
        int unsigned i;
        i = (a / 16) % 16;
        if (m_mis(op, a)) return 0;
        if (rw == CACHE_WRITE) return 1;
        return (mvalid[i] && mtag[i] == a / 256) ? 0 : 4;
    endfunction
    function automatic logic [31:0] m_mask(input cache_operation op);
        return op == CACHE_BYTE ? 32'hFF : op == CACHE_HALF ? 32'hFFFF : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] m_data(input cache_operation op, input logic [31:0] a);
        return (ref_rd(a / 4) >> (8 * (a % 4))) & m_mask(op);
    endfunction
    function automatic logic [3:0] m_strb(input cache_operation op, input logic [31:0] a);
        return op == CACHE_BYTE ? 4'b0001 << (a % 4) : op == CACHE_HALF ? 4'b0011 << (a % 4) : 4'b1111;
    endfunction
    function automatic void m_update(input cache_rw rw, input cache_operation op, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w, sh;
        logic [3:0] s;
        if (m_mis(op, a)) return;
        if (rw == CACHE_READ) begin
            mvalid[(a / 16) % 16] = 1'b1;
            mtag[(a / 16) % 16] = a / 256;
        end else begin
            w = ref_rd(a / 4);
            sh = wd << (8 * (a % 4));
            s = m_strb(op, a);
            for (int b = 0; b < 4; b++)
                if (s[b]) w[8*b +: 8] = sh[8*b +: 8];
            ref_mem[a / 4] = w;
        end
    endfunction

    // backing memory: random ack latency, logs every acked beat, checks request stability
    initial begin
        logic [31:0] h_addr, h_wdata, w;
        logic h_we;
        logic [3:0] h_strb;
        bit pend;
        pend = 0;
        i_mem_ack = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(posedge i_clk);
            #1;
            i_mem_ack = 1'b0;
            if (!o_mem_req)
                pend = 0;
            else begin
                if (pend) begin
                    chk("mem_hold_addr", o_mem_addr, h_addr);
                    chk("mem_hold_ctl", {27'b0, o_mem_we, o_mem_wstrb}, {27'b0, h_we, h_strb});
                    chk("mem_hold_wdata", o_mem_wdata, h_wdata);
                end else begin
                    pend = 1;
                    h_addr = o_mem_addr;
                    h_we = o_mem_we;
                    h_strb = o_mem_wstrb;
                    h_wdata = o_mem_wdata;
                    wait_cnt = slow ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
                end
                if (wait_cnt == 0) begin
                    i_mem_ack = 1'b1;
                    i_mem_rdata = mem_rd(o_mem_addr / 4);
                    if (o_mem_we) begin
                        w = mem_rd(o_mem_addr / 4);
                        for (int b = 0; b < 4; b++)
                            if (o_mem_wstrb[b]) w[8*b +: 8] = o_mem_wdata[8*b +: 8];
                        mem[o_mem_addr / 4] = w;
                    end
                    beats_q.push_back('{o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wstrb});
                    pend = 0;
                end else
                    wait_cnt--;
            end
        end
    end

    task automatic do_op(input int id, input cache_rw rw, input cache_operation op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] e_data, input bit e_mis, input int e_beats,
                         input logic [3:0] e_strb, input logic [31:0] e_wdata);
        int cyc;
        bit seen;
        logic [31:0] ea;
        cyc = 0;
        seen = 0;
        chk($sformatf("op%0d_ready", id), 32'(o_ready), 32'd1);
        beats_q.delete();
        i_req = 1'b1;
        i_address = a;
        i_write_data = wd;
        i_read_or_write = rw;
        i_operation = op;
        @(posedge i_clk);
        #2;
        i_req = 1'b0;
        while (!seen && cyc < 200) begin
            if (o_done) seen = 1;
            else begin
                @(posedge i_clk);
                #2;
                cyc++;
            end
        end
        chk($sformatf("op%0d_done", id), 32'(seen), 32'd1);
        if (seen) begin
            chk($sformatf("op%0d_mis", id), 32'(o_misaligned), 32'(e_mis));
            if (rw == CACHE_READ && !e_mis) chk($sformatf("op%0d_data", id), o_data, e_data);
            chk($sformatf("op%0d_beats", id), beats_q.size(), e_beats);
            if (e_beats == 0) chk($sformatf("op%0d_latency", id), cyc, 1);
            for (int k = 0; k < beats_q.size() && k < e_beats; k++) begin
                ea = rw == CACHE_WRITE ? a & ~32'h3 : (a & ~32'hF) + 32'(4 * k);
                chk($sformatf("op%0d_b%0d_addr", id, k), beats_q[k].addr, ea);
                chk($sformatf("op%0d_b%0d_we", id, k), 32'(beats_q[k].we), 32'(rw == CACHE_WRITE));
                if (rw == CACHE_WRITE) begin
                    chk($sformatf("op%0d_strb", id), 32'(beats_q[k].wstrb), 32'(e_strb));
                    chk($sformatf("op%0d_wdata", id), beats_q[k].wdata, e_wdata);
                end
            end
            @(posedge i_clk);
            #2;
            chk($sformatf("op%0d_pulse", id), 32'(o_done), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a, wd;
        cache_rw rw;
        cache_operation op;
        int cyc, nb;
        bit quiet_bad;
        i_reset = 1'b1;
        i_req = 1'b0;
        i_address = '0;
        i_write_data = '0;
        i_read_or_write = CACHE_READ;
        i_operation = CACHE_WORD;
        mem[32'h40] = 32'hAABBCCDD;
        ref_mem[32'h40] = 32'hAABBCCDD;
        repeat (3) @(posedge i_clk);
        #2;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_mis", 32'(o_misaligned), 32'd0);
        chk("rst_mem_req", 32'(o_mem_req), 32'd0);
        chk("rst_mem_we", 32'(o_mem_we), 32'd0);
        chk("rst_data", o_data, 32'd0);
        i_reset = 1'b0;
        @(posedge i_clk);
        #2;
        chk("post_rst_ready", 32'(o_ready), 32'd1);

        vt.push_back('{CACHE_READ,  CACHE_WORD, 32'h100, 32'h0,        32'hAABBCCDD, 0, 4, 4'h0, 32'h0});
        vt.push_back('{CACHE_READ,  CACHE_WORD, 32'h100, 32'h0,        32'hAABBCCDD, 0, 0, 4'h0, 32'h0});
        vt.push_back('{CACHE_READ,  CACHE_BYTE, 32'h103, 32'h0,        32'h000000AA, 0, 0, 4'h0, 32'h0});
        vt.push_back('{CACHE_WRITE, CACHE_HALF, 32'h102, 32'h1234,     32'h0,        0, 1, 4'hC, 32'h12340000});
        vt.push_back('{CACHE_READ,  CACHE_WORD, 32'h100, 32'h0,        32'h1234CCDD, 0, 0, 4'h0, 32'h0});
        vt.push_back('{CACHE_READ,  CACHE_HALF, 32'h101, 32'h0,        32'h0,        1, 0, 4'h0, 32'h0});
        vt.push_back('{CACHE_READ,  CACHE_WORD, 32'h200, 32'h0,        init_word(32'h80), 0, 4, 4'h0, 32'h0});
        vt.push_back('{CACHE_READ,  CACHE_WORD, 32'h100, 32'h0,        32'h1234CCDD, 0, 4, 4'h0, 32'h0});
        vt.push_back('{CACHE_READ,  CACHE_BYTE, 32'h10E, 32'h0,        (init_word(32'h43) >> 16) & 32'hFF, 0, 0, 4'h0, 32'h0});
        vt.push_back('{CACHE_WRITE, CACHE_WORD, 32'h344, 32'hCAFEF00D, 32'h0,        0, 1, 4'hF, 32'hCAFEF00D});
        vt.push_back('{CACHE_READ,  CACHE_WORD, 32'h344, 32'h0,        32'hCAFEF00D, 0, 4, 4'h0, 32'h0});
        vt.push_back('{CACHE_WRITE, CACHE_BYTE, 32'h101, 32'hEE,       32'h0,        0, 1, 4'h2, 32'h0000EE00});
        vt.push_back('{CACHE_READ,  CACHE_WORD, 32'h100, 32'h0,        32'h1234EEDD, 0, 0, 4'h0, 32'h0});
        vt.push_back('{CACHE_WRITE, CACHE_WORD, 32'h102, 32'h55,       32'h0,        1, 0, 4'h0, 32'h0});
        vt.push_back('{CACHE_READ,  CACHE_HALF, 32'h10E, 32'h0,        (init_word(32'h43) >> 16) & 32'hFFFF, 0, 0, 4'h0, 32'h0});
        foreach (vt[i]) begin
            do_op(i, vt[i].rw, vt[i].op, vt[i].addr, vt[i].wd, vt[i].e_data, vt[i].e_mis, vt[i].e_beats,
                  vt[i].e_strb, vt[i].e_wdata);
            m_update(vt[i].rw, vt[i].op, vt[i].addr, vt[i].wd);
        end

        // reset during the third refill beat aborts the refill and leaves the line invalid
        i_reset = 1'b1;
        @(posedge i_clk);
        #2;
        i_reset = 1'b0;
        foreach (mvalid[i]) mvalid[i] = 0;
        slow = 1;
        beats_q.delete();
        i_req = 1'b1;
        i_address = 32'h100;
        i_read_or_write = CACHE_READ;
        i_operation = CACHE_WORD;
        @(posedge i_clk);
        #2;
        i_req = 1'b0;
        cyc = 0;
        while (!(beats_q.size() == 2 && !i_mem_ack && o_mem_req) && cyc < 100) begin
            @(posedge i_clk);
            #2;
            cyc++;
        end
        chk("abort_reach_beat3", 32'(cyc < 100), 32'd1);
        i_reset = 1'b1;
        @(posedge i_clk);
        #2;
        chk("abort_mem_req", 32'(o_mem_req), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        i_reset = 1'b0;
        slow = 0;
        quiet_bad = 0;
        repeat (8) begin
            @(posedge i_clk);
            #2;
            if (o_done || o_mem_req) quiet_bad = 1;
        end
        chk("abort_quiet", 32'(quiet_bad), 32'd0);
        foreach (mvalid[i]) mvalid[i] = 0;
        do_op(100, CACHE_READ, CACHE_WORD, 32'h100, 32'h0, ref_rd(32'h40), 0, 4, 4'h0, 32'h0);
        m_update(CACHE_READ, CACHE_WORD, 32'h100, 32'h0);

        for (int i = 0; i < 150; i++) begin
            a = (32'($urandom_range(1, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
            rw = cache_rw'($urandom_range(0, 1));
            op = cache_operation'($urandom_range(0, 2));
            wd = $urandom & m_mask(op);
            nb = m_beats(rw, op, a);
            do_op(200 + i, rw, op, a, wd, m_data(op, a), m_mis(op, a), nb, m_strb(op, a), wd << (8 * (a % 4)));
            m_update(rw, op, a, wd);
            repeat ($urandom_range(0, 2)) begin
                @(posedge i_clk);
                #2;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
